// File: rtl/checkpoint_restore_controller.sv
// Initiator side of the map-table checkpoint save/restore protocol: tracks outstanding branch
// checkpoints in age order and issues restore requests when a tracked branch resolves.
module checkpoint_restore_controller #(
  parameter int unsigned CKPT_ENTRIES    = 3,
  parameter int unsigned RETRY_LIMIT     = 15,
  parameter int unsigned ROB_INDEX_WIDTH = 6,
  parameter int unsigned COLUMN_WIDTH    = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ckpt_alloc_valid,
  input  logic [ROB_INDEX_WIDTH-1:0] ckpt_alloc_ROB_index,
  input  logic [COLUMN_WIDTH-1:0]    ckpt_alloc_safe_column,
  output logic                       ckpt_alloc_ready,
  input  logic                       resolve_valid,
  input  logic [ROB_INDEX_WIDTH-1:0] resolve_ROB_index,
  input  logic                       resolve_mispredict,
  output logic                       resolve_ready,
  output logic                       restore_checkpoint_valid,
  output logic                       restore_checkpoint_speculate_failed,
  output logic [ROB_INDEX_WIDTH-1:0] restore_checkpoint_ROB_index,
  output logic [COLUMN_WIDTH-1:0]    restore_checkpoint_safe_column,
  input  logic                       restore_checkpoint_success,
  output logic                       flush_pipeline,
  output logic                       restore_error,
  output logic                       busy
);

  localparam int unsigned IdxW   = (CKPT_ENTRIES > 1) ? $clog2(CKPT_ENTRIES) : 1;
  localparam int unsigned CntW   = $clog2(CKPT_ENTRIES + 1);
  localparam int unsigned RetryW = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e                     state_q, state_d;
  logic [CKPT_ENTRIES-1:0]    entry_valid_q, entry_valid_d;
  logic [ROB_INDEX_WIDTH-1:0] entry_rob_q [CKPT_ENTRIES];
  logic [COLUMN_WIDTH-1:0]    entry_col_q [CKPT_ENTRIES];
  logic [IdxW-1:0]            head_q, head_d, tail_q, tail_d, match_q, match_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [RetryW-1:0]          retry_q, retry_d;
  logic [ROB_INDEX_WIDTH-1:0] req_rob_q, req_rob_d;
  logic [COLUMN_WIDTH-1:0]    req_col_q, req_col_d;
  logic                       req_spec_q, req_spec_d;
  logic                       flush_q, flush_d;
  logic                       error_q, error_d;

  logic            alloc_ready, alloc_fire, reclaim, match_hit;
  logic [IdxW-1:0] match_idx;

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] idx);
    return (int'(idx) == int'(CKPT_ENTRIES) - 1) ? '0 : idx + IdxW'(1);
  endfunction

  // Distance from head to idx going forward around the ring, i.e. the entry's age rank.
  function automatic int unsigned age_of(input logic [IdxW-1:0] idx, input logic [IdxW-1:0] head);
    return (idx >= head) ? int'(idx) - int'(head) : int'(idx) + int'(CKPT_ENTRIES) - int'(head);
  endfunction

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = int'(CKPT_ENTRIES) - 1; i >= 0; i--) begin
      if (entry_valid_q[i] && entry_rob_q[i] == resolve_ROB_index) begin
        match_hit = 1'b1;
        match_idx = IdxW'(i);
      end
    end
  end

  assign alloc_ready = (state_q == StIdle) && (count_q != CntW'(CKPT_ENTRIES));
  assign alloc_fire  = ckpt_alloc_valid && alloc_ready;
  assign reclaim     = (count_q != '0) && !entry_valid_q[head_q];

  always_comb begin
    state_d       = state_q;
    entry_valid_d = entry_valid_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + CntW'(alloc_fire) - CntW'(reclaim);
    match_d       = match_q;
    retry_d       = retry_q;
    req_rob_d     = req_rob_q;
    req_col_d     = req_col_q;
    req_spec_d    = req_spec_q;
    flush_d       = 1'b0;
    error_d       = error_q;

    if (reclaim) head_d = idx_inc(head_q);
    if (alloc_fire) begin
      entry_valid_d[tail_q] = 1'b1;
      tail_d                = idx_inc(tail_q);
    end
    if (ckpt_alloc_valid && !alloc_ready) error_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (resolve_valid) begin
          if (match_hit) begin
            match_d    = match_idx;
            req_rob_d  = entry_rob_q[match_idx];
            req_col_d  = entry_col_q[match_idx];
            req_spec_d = resolve_mispredict;
            retry_d    = '0;
            state_d    = StReq;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (restore_checkpoint_success) begin
          state_d = StIdle;
          if (!req_spec_q) begin
            entry_valid_d[match_q] = 1'b0;
          end else begin
            // Squash the matched entry and everything allocated after it.
            for (int i = 0; i < int'(CKPT_ENTRIES); i++) begin
              if (age_of(IdxW'(i), head_q) >= age_of(match_q, head_q) &&
                  age_of(IdxW'(i), head_q) < int'(count_q)) begin
                entry_valid_d[i] = 1'b0;
              end
            end
            tail_d  = match_q;
            count_d = CntW'(age_of(match_q, head_d));
            flush_d = 1'b1;
          end
        end else if (retry_q == RetryW'(RETRY_LIMIT - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          retry_d = retry_q + RetryW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StIdle;
      entry_valid_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      match_q       <= '0;
      retry_q       <= '0;
      req_rob_q     <= '0;
      req_col_q     <= '0;
      req_spec_q    <= 1'b0;
      flush_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_valid_q <= entry_valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      match_q       <= match_d;
      retry_q       <= retry_d;
      req_rob_q     <= req_rob_d;
      req_col_q     <= req_col_d;
      req_spec_q    <= req_spec_d;
      flush_q       <= flush_d;
      error_q       <= error_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(CKPT_ENTRIES); i++) begin
        entry_rob_q[i] <= '0;
        entry_col_q[i] <= '0;
      end
    end else if (alloc_fire) begin
      entry_rob_q[tail_q] <= ckpt_alloc_ROB_index;
      entry_col_q[tail_q] <= ckpt_alloc_safe_column;
    end
  end

  assign ckpt_alloc_ready                    = alloc_ready;
  assign resolve_ready                       = (state_q == StIdle);
  assign busy                                = (state_q != StIdle);
  assign restore_checkpoint_valid            = (state_q == StReq);
  assign restore_checkpoint_speculate_failed = req_spec_q;
  assign restore_checkpoint_ROB_index        = req_rob_q;
  assign restore_checkpoint_safe_column      = req_col_q;
  assign flush_pipeline                      = flush_q;
  assign restore_error                       = error_q;

endmodule

// File: tb/tb_checkpoint_restore_controller.sv
// Directed bench for checkpoint_restore_controller: allocation, restore handshake, squash,
// miss/retry errors, pointer wrap and asynchronous reset.
module tb_checkpoint_restore_controller;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ckpt_alloc_valid;
  logic [5:0] ckpt_alloc_ROB_index;
  logic [1:0] ckpt_alloc_safe_column;
  logic       ckpt_alloc_ready;
  logic       resolve_valid;
  logic [5:0] resolve_ROB_index;
  logic       resolve_mispredict;
  logic       resolve_ready;
  logic       restore_checkpoint_valid;
  logic       restore_checkpoint_speculate_failed;
  logic [5:0] restore_checkpoint_ROB_index;
  logic [1:0] restore_checkpoint_safe_column;
  logic       restore_checkpoint_success;
  logic       flush_pipeline;
  logic       restore_error;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  checkpoint_restore_controller dut (
    .CLK                                 (CLK),
    .nRST                                (nRST),
    .ckpt_alloc_valid                    (ckpt_alloc_valid),
    .ckpt_alloc_ROB_index                (ckpt_alloc_ROB_index),
    .ckpt_alloc_safe_column              (ckpt_alloc_safe_column),
    .ckpt_alloc_ready                    (ckpt_alloc_ready),
    .resolve_valid                       (resolve_valid),
    .resolve_ROB_index                   (resolve_ROB_index),
    .resolve_mispredict                  (resolve_mispredict),
    .resolve_ready                       (resolve_ready),
    .restore_checkpoint_valid            (restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column      (restore_checkpoint_safe_column),
    .restore_checkpoint_success          (restore_checkpoint_success),
    .flush_pipeline                      (flush_pipeline),
    .restore_error                       (restore_error),
    .busy                                (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST                       = 1'b0;
    ckpt_alloc_valid           = 1'b0;
    ckpt_alloc_ROB_index       = '0;
    ckpt_alloc_safe_column     = '0;
    resolve_valid              = 1'b0;
    resolve_ROB_index          = '0;
    resolve_mispredict         = 1'b0;
    restore_checkpoint_success = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic alloc(input logic [5:0] rob, input logic [1:0] col);
    ckpt_alloc_valid       = 1'b1;
    ckpt_alloc_ROB_index   = rob;
    ckpt_alloc_safe_column = col;
    step();
    ckpt_alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic [5:0] rob, input logic mp);
    resolve_valid      = 1'b1;
    resolve_ROB_index  = rob;
    resolve_mispredict = mp;
    step();
    resolve_valid = 1'b0;
  endtask

  task automatic succeed();
    restore_checkpoint_success = 1'b1;
    step();
    restore_checkpoint_success = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic spec, input logic [5:0] rob,
                           input logic [1:0] col);
    check_eq({tag, "_valid"}, restore_checkpoint_valid, 1'b1);
    check_eq({tag, "_spec"}, restore_checkpoint_speculate_failed, spec);
    check_eq({tag, "_rob"}, restore_checkpoint_ROB_index, rob);
    check_eq({tag, "_col"}, restore_checkpoint_safe_column, col);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int cyc;

    // Reset state
    do_reset();
    check_eq("rst_alloc_ready", ckpt_alloc_ready, 1'b1);
    check_eq("rst_resolve_ready", resolve_ready, 1'b1);
    check_eq("rst_valid", restore_checkpoint_valid, 1'b0);
    check_eq("rst_error", restore_error, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_flush", flush_pipeline, 1'b0);

    // Correct-prediction restore, success in first REQ cycle
    alloc(6'd5, 2'd0);
    alloc(6'd9, 2'd1);
    check_eq("two_alloc_ready", ckpt_alloc_ready, 1'b1);
    alloc(6'd12, 2'd2);
    check_eq("full_alloc_ready", ckpt_alloc_ready, 1'b0);
    resolve(6'd9, 1'b0);
    check_req("corr_req", 1'b0, 6'd9, 2'd1);
    check_eq("corr_busy", busy, 1'b1);
    check_eq("corr_resolve_ready", resolve_ready, 1'b0);
    succeed();
    check_eq("corr_done_valid", restore_checkpoint_valid, 1'b0);
    check_eq("corr_no_flush", flush_pipeline, 1'b0);
    check_eq("corr_resolve_ready2", resolve_ready, 1'b1);
    check_eq("corr_no_error", restore_error, 1'b0);
    resolve(6'd9, 1'b0);
    check_eq("cleared_entry_miss", restore_error, 1'b1);
    check_eq("cleared_entry_noreq", restore_checkpoint_valid, 1'b0);

    // Mispredict restore with success withheld three cycles
    do_reset();
    alloc(6'd5, 2'd0);
    alloc(6'd9, 2'd1);
    alloc(6'd12, 2'd2);
    resolve(6'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_req("mis_hold", 1'b1, 6'd5, 2'd0);
      step();
    end
    check_req("mis_last", 1'b1, 6'd5, 2'd0);
    succeed();
    check_eq("mis_done_valid", restore_checkpoint_valid, 1'b0);
    check_eq("mis_flush", flush_pipeline, 1'b1);
    check_eq("mis_busy", busy, 1'b0);
    step();
    check_eq("mis_flush_pulse", flush_pipeline, 1'b0);
    check_eq("mis_empty_ready", ckpt_alloc_ready, 1'b1);
    alloc(6'd20, 2'd1);
    alloc(6'd21, 2'd2);
    check_eq("mis_refill2_ready", ckpt_alloc_ready, 1'b1);
    alloc(6'd22, 2'd0);
    check_eq("mis_refill3_ready", ckpt_alloc_ready, 0);
    check_eq("mis_no_error", restore_error, 1'b0);
    resolve(6'd12, 1'b0);
    check_eq("mis_squashed_miss", restore_error, 1'b1);
    resolve(6'd21, 1'b0);
    check_req("mis_refill_req", 1'b0, 6'd21, 2'd2);
    succeed();

    // Resolve with no matching entry
    do_reset();
    resolve(6'd7, 1'b0);
    check_eq("miss_error", restore_error, 1'b1);
    check_eq("miss_valid", restore_checkpoint_valid, 1'b0);
    check_eq("miss_busy", busy, 1'b0);
    step();
    check_eq("miss_error_sticky", restore_error, 1'b1);

    // Retry limit
    do_reset();
    alloc(6'd3, 2'd2);
    resolve(6'd3, 1'b0);
    check_eq("retry_no_error_yet", restore_error, 1'b0);
    cyc = 0;
    while (restore_checkpoint_valid && cyc < 40) begin
      cyc++;
      step();
    end
    check_eq("retry_req_cycles", cyc, 15);
    check_eq("retry_error", restore_error, 1'b1);
    check_eq("retry_idle", busy, 1'b0);
    resolve(6'd3, 1'b0);
    check_req("retry_entry_kept", 1'b0, 6'd3, 2'd2);
    succeed();

    // Wrap-around over ten branches
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [5:0] rob;
      logic [1:0] col;
      rob = 6'(10 + i);
      col = 2'(i % 3);
      check_eq("wrap_alloc_ready", ckpt_alloc_ready, 1'b1);
      alloc(rob, col);
      resolve(rob, 1'b0);
      check_req("wrap_req", 1'b0, rob, col);
      succeed();
      check_eq("wrap_done", restore_checkpoint_valid, 1'b0);
    end
    check_eq("wrap_no_error", restore_error, 1'b0);

    // Asynchronous reset in the middle of a request
    alloc(6'd1, 2'd1);
    resolve(6'd1, 1'b1);
    check_eq("arst_pre_valid", restore_checkpoint_valid, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("arst_valid", restore_checkpoint_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_resolve_ready", resolve_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    check_eq("arst_after_valid", restore_checkpoint_valid, 1'b0);
    check_eq("arst_after_flush", flush_pipeline, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/checkpoint_restore_controller.md
Name: checkpoint_restore_controller

Overview:
Initiator side of the map-table checkpoint save/restore protocol. It sits in the core beside the branch resolution logic. It tracks every outstanding branch checkpoint (ROB index plus safe column) in age order. When a tracked branch resolves, it drives restore_checkpoint_* to the physical register map table and holds the request until success. On a mispredict it then squashes younger checkpoints and pulses a pipeline flush.

Parameters:
CKPT_ENTRIES, CHECKPOINT_COLUMNS-1 (3), max outstanding checkpoints; one map-table column is always the working column.
RETRY_LIMIT, 15, consecutive unsuccessful REQ cycles before the request is abandoned.

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ckpt_alloc_valid  in  1  a branch saved a checkpoint this cycle
ckpt_alloc_ROB_index  in  ROB_index_t  ROB index of that branch
ckpt_alloc_safe_column  in  checkpoint_column_t  safe column returned by the map table
ckpt_alloc_ready  out  1  an entry is free and the FSM is IDLE
resolve_valid  in  1  a branch resolved
resolve_ROB_index  in  ROB_index_t  ROB index of the resolved branch
resolve_mispredict  in  1  1 = speculation failed
resolve_ready  out  1  FSM is IDLE
restore_checkpoint_valid  out  1  restore request to the map table
restore_checkpoint_speculate_failed  out  1  latched resolve_mispredict
restore_checkpoint_ROB_index  out  ROB_index_t  latched ROB index
restore_checkpoint_safe_column  out  checkpoint_column_t  safe column of the matched entry
restore_checkpoint_success  in  1  map table accepted the request
flush_pipeline  out  1  one-cycle pulse after a successful mispredict restore
restore_error  out  1  sticky error flag; cleared only by reset
busy  out  1  FSM is not IDLE

Behaviour:
- Reset:
  - All entries invalid; head = tail = count = 0; FSM IDLE; retry counter 0.
  - All outputs 0, except ckpt_alloc_ready = 1 and resolve_ready = 1.
  - Reset mid-request drops the request immediately and asynchronously.
- Storage: circular buffer of CKPT_ENTRIES entries, each {valid, ROB_index, safe_column}. Head is the oldest entry, tail the next free slot. count is the head-to-tail distance.
- Allocation:
  - Accepted when ckpt_alloc_valid & ckpt_alloc_ready. The entry is written at tail, tail increments modulo CKPT_ENTRIES, count increments.
  - ckpt_alloc_valid while not ready is ignored and sets restore_error.
- Head reclaim: each cycle, if count > 0 and the head entry is invalid, head increments by 1 and count decrements by 1. At most one reclaim per cycle.
- A simultaneous alloc and reclaim leaves count unchanged.
- FSM IDLE, on resolve_valid:
  - Associative match on valid entries by ROB_index.
  - Hit: latch the matched index, ROB index, safe column and mispredict; go to REQ.
  - Miss: set restore_error and stay IDLE.
  - An allocation in the same cycle is accepted and does not participate in the match.
- FSM REQ:
  - restore_checkpoint_valid = 1 and the latched fields are held stable; no allocations are accepted.
  - If restore_checkpoint_success: correct prediction clears the matched entry's valid bit. Mispredict clears the matched entry and all younger entries, sets tail to the matched index, and recomputes count. Next state is IDLE.
  - Else the retry counter increments. When it reaches RETRY_LIMIT, set restore_error, leave entries unchanged, and go to IDLE.
- Retry counter clears on every entry into REQ.
- flush_pipeline is registered: it is high for exactly the first IDLE cycle after a successful mispredict restore.
- Tracker state is updated from outputs valid in the cycle success is sampled; there is no combinational path from restore_checkpoint_success to restore_checkpoint_valid.
- Wrap-around: head, tail and the match index wrap modulo CKPT_ENTRIES. Full is defined as count == CKPT_ENTRIES; empty as count == 0.

Test Plan:
1. Reset -> ckpt_alloc_ready=1, resolve_ready=1, restore_checkpoint_valid=0, restore_error=0, count=0.
2. Allocate ROB 5/col 0, ROB 9/col 1, ROB 12/col 2 -> ckpt_alloc_ready=0. Resolve ROB 9 correct with success in 1st REQ cycle -> request {spec_failed=0, ROB 9, col 1} seen for 1 cycle; no flush; entry cleared.
3. Same three entries, resolve ROB 5 mispredict; success withheld 3 cycles then given -> valid held 4 cycles with fields stable; then flush_pipeline pulses 1 cycle, count=0, tail=head.
4. Resolve ROB 7 with no matching entry -> restore_error=1, FSM stays IDLE, no request issued.
5. Hold success low -> after 15 REQ cycles, restore_error=1, FSM IDLE, entry still valid.
6. Fill, resolve-correct and reclaim repeatedly for 10 branches -> pointers wrap and safe columns are returned unchanged. Assert nRST mid-REQ -> valid=0 immediately.
